axi_rd_arbiter: RTL and testbench
=================================

Name: axi_rd_arbiter

Overview:
- Shares the single AXI read master (AR + R channels) between two requesters: instruction fetch (IF) and data load (MEM).
- Sits between the PC/IF stage and MEM stage on one side and the AXI interconnect on the other.
- Grants one requester at a time and holds the grant from the AR issue through the last R beat.
- Latches the winner's address, length and size, then routes the R beats back to that requester only.

Parameters:
ADDR_W, 64, AR address width
DATA_W, 64, R data width
LEN_W, 8, AR burst length width (AXI len = beats-1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
if_ar_valid  in  1  IF read request
if_ar_ready  out  1  IF request accepted (1-cycle pulse)
if_addr  in  ADDR_W  IF read address
if_len  in  LEN_W  IF burst length
if_size  in  2  IF beat size
if_r_valid  out  1  IF read beat valid
if_r_ready  in  1  IF can take beat
if_r_data  out  DATA_W  read data to IF
if_r_resp  out  2  response to IF
if_r_last  out  1  last beat to IF
mem_ar_valid, mem_ar_ready, mem_addr, mem_len, mem_size, mem_r_valid, mem_r_ready, mem_r_data, mem_r_resp, mem_r_last: same as IF set, for MEM
axi_ar_valid  out  1  AR valid
axi_ar_ready  in  1  AR ready
axi_ar_addr  out  ADDR_W  AR address
axi_ar_len  out  LEN_W  AR length
axi_ar_size  out  3  AR size ({1'b0, size})
axi_ar_id  out  4  0 = IF, 1 = MEM
axi_r_valid  in  1  R valid
axi_r_ready  out  1  R ready
axi_r_data  in  DATA_W  R data
axi_r_resp  in  2  R response
axi_r_last  in  1  R last

Behaviour:
- States: IDLE, ADDR, DATA. The owner register is 0 for IF and 1 for MEM.
- Reset (reset=0, async):
  - state=IDLE, owner=0.
  - axi_ar_valid=0.
  - axi_ar_addr, axi_ar_len, axi_ar_size and axi_ar_id = 0.
  - Both *_ar_ready = 0.
- IDLE, any request valid:
  - Choose the winner. MEM wins if both are valid (default policy).
  - Register the winner's addr/len/size/id into the AR registers.
  - Set owner and pulse the winner's *_ar_ready for that same cycle only. The loser sees ar_ready=0.
  - Next state ADDR. axi_ar_valid rises on the next cycle (1-cycle latency).
- ADDR:
  - axi_ar_valid=1. AR fields stay stable until axi_ar_ready.
  - On the handshake: axi_ar_valid drops the next cycle and state goes to DATA.
- DATA:
  - R channel routing is combinational to the owner: owner_r_valid = axi_r_valid; data, resp and last pass through; axi_r_ready = owner_r_ready.
  - The non-owner's r_valid is 0.
  - Handshake with axi_r_last=1: go to IDLE.
  - A new AR can be accepted at the earliest in the cycle after returning to IDLE, so there is no back-to-back overlap.
- Requests that arrive in ADDR or DATA get no ar_ready. The requester must hold valid and stable fields until it sees ar_ready.
- axi_r_valid outside DATA: axi_r_ready=0 and the beat is not forwarded.
- Error responses (resp≠0) are forwarded unchanged. Arbitration is unaffected.
- Reset during ADDR or DATA aborts the transaction immediately and all outputs take their reset values. The interconnect must be reset together with this block.

Optional Feature:
Macro YSYX_22041071_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-grant register (reset to 0 = IF) is updated on every grant.
  - On contention, the requester not granted last wins.
- Undefined: fixed priority, MEM over IF. No last-grant register.

Test Plan:
- Single IF request, addr=0x8000_0000, len=0, size=3 → if_ar_ready pulses in cycle N. AR goes out in N+1 with id=0, addr=0x8000_0000, axi_ar_size=3'b011. One R beat 0x1234 appears on if_r_data. mem_r_valid stays 0. State returns to IDLE.
- IF and MEM valid in the same cycle (MEM addr=0x8000_1000) → MEM granted first (id=1). IF granted after MEM's r_last. With RR_EN, a second contention grants IF first.
- axi_ar_ready held low 5 cycles → axi_ar_valid, addr, len and id stay constant for all 5 cycles. Exactly one handshake occurs.
- MEM burst len=3 with mem_r_ready toggled 1,0,1,0… → 4 beats delivered in order. axi_r_ready mirrors mem_r_ready. IDLE is re-entered only after the 4th (last) beat.
- IF request issued during a MEM DATA phase → no if_ar_ready until MEM r_last. IF is then granted with a 1-cycle IDLE gap.
- Reset asserted in DATA after 2 of 4 beats → asynchronous clear: axi_ar_valid=0, axi_r_ready=0, both r_valid=0, state IDLE. After release, a new IF request is granted normally.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI read master (AR + R channels) between IF and MEM requesters.
// Optional macro YSYX_22041071_ARB_RR_EN selects round-robin; default is fixed MEM-over-IF priority.
module axi_rd_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  // instruction fetch requester
  input  logic              if_ar_valid,
  output logic              if_ar_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic [LEN_W-1:0]  if_len,
  input  logic [1:0]        if_size,
  output logic              if_r_valid,
  input  logic              if_r_ready,
  output logic [DATA_W-1:0] if_r_data,
  output logic [1:0]        if_r_resp,
  output logic              if_r_last,
  // data load requester
  input  logic              mem_ar_valid,
  output logic              mem_ar_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [LEN_W-1:0]  mem_len,
  input  logic [1:0]        mem_size,
  output logic              mem_r_valid,
  input  logic              mem_r_ready,
  output logic [DATA_W-1:0] mem_r_data,
  output logic [1:0]        mem_r_resp,
  output logic              mem_r_last,
  // AXI read master
  output logic              axi_ar_valid,
  input  logic              axi_ar_ready,
  output logic [ADDR_W-1:0] axi_ar_addr,
  output logic [LEN_W-1:0]  axi_ar_len,
  output logic [2:0]        axi_ar_size,
  output logic [3:0]        axi_ar_id,
  input  logic              axi_r_valid,
  output logic              axi_r_ready,
  input  logic [DATA_W-1:0] axi_r_data,
  input  logic [1:0]        axi_r_resp,
  input  logic              axi_r_last
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] ar_addr_q, ar_addr_d;
  logic [LEN_W-1:0]  ar_len_q, ar_len_d;
  logic [2:0]        ar_size_q, ar_size_d;
  logic [3:0]        ar_id_q, ar_id_d;

  logic any_req;
  logic grant_mem;
  logic accept;
  logic owner_r_ready;
  logic r_last_fire;

  // Grants are only issued while out of reset so both ar_ready pulses stay low during reset.
  assign any_req       = if_ar_valid | mem_ar_valid;
  assign accept        = reset & (state_q == IDLE) & any_req;
  assign owner_r_ready = owner_q ? mem_r_ready : if_r_ready;
  assign r_last_fire   = (state_q == DATA) & axi_r_valid & owner_r_ready & axi_r_last;

`ifdef YSYX_22041071_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On contention the requester that did not win last time gets the bus.
  always_comb begin
    grant_mem = mem_ar_valid;
    if (if_ar_valid && mem_ar_valid) begin
      grant_mem = ~last_grant_q;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) begin
      last_grant_d = grant_mem;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  always_comb grant_mem = mem_ar_valid;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      ar_addr_q <= '0;
      ar_len_q  <= '0;
      ar_size_q <= '0;
      ar_id_q   <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ar_addr_q <= ar_addr_d;
      ar_len_q  <= ar_len_d;
      ar_size_q <= ar_size_d;
      ar_id_q   <= ar_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    if (axi_ar_ready) state_d = DATA;
      DATA:    if (r_last_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The AR fields are captured once at grant time and held for the whole transaction.
  always_comb begin
    owner_d   = owner_q;
    ar_addr_d = ar_addr_q;
    ar_len_d  = ar_len_q;
    ar_size_d = ar_size_q;
    ar_id_d   = ar_id_q;
    if (accept) begin
      owner_d = grant_mem;
      ar_id_d = {3'b000, grant_mem};
      if (grant_mem) begin
        ar_addr_d = mem_addr;
        ar_len_d  = mem_len;
        ar_size_d = {1'b0, mem_size};
      end else begin
        ar_addr_d = if_addr;
        ar_len_d  = if_len;
        ar_size_d = {1'b0, if_size};
      end
    end
  end

  assign axi_ar_addr = ar_addr_q;
  assign axi_ar_len  = ar_len_q;
  assign axi_ar_size = ar_size_q;
  assign axi_ar_id   = ar_id_q;

  // R beats reach only the owner and only during DATA; stray beats elsewhere are never accepted.
  always_comb begin
    axi_ar_valid = (state_q == ADDR);
    if_ar_ready  = 1'b0;
    mem_ar_ready = 1'b0;
    axi_r_ready  = 1'b0;
    if_r_valid   = 1'b0;
    if_r_data    = '0;
    if_r_resp    = '0;
    if_r_last    = 1'b0;
    mem_r_valid  = 1'b0;
    mem_r_data   = '0;
    mem_r_resp   = '0;
    mem_r_last   = 1'b0;
    if (accept) begin
      if_ar_ready  = ~grant_mem;
      mem_ar_ready = grant_mem;
    end
    if (state_q == DATA) begin
      axi_r_ready = owner_r_ready;
      if (owner_q) begin
        mem_r_valid = axi_r_valid;
        mem_r_data  = axi_r_data;
        mem_r_resp  = axi_r_resp;
        mem_r_last  = axi_r_last;
      end else begin
        if_r_valid = axi_r_valid;
        if_r_data  = axi_r_data;
        if_r_resp  = axi_r_resp;
        if_r_last  = axi_r_last;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized traffic,
// all compared every cycle against a transaction-level reference model.
module tb_axi_rd_arbiter;

   localparam int ADDR_W = 64;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 8;

   localparam int PH_FREE = 0;
   localparam int PH_ADDR = 1;
   localparam int PH_DATA = 2;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_ar_valid, if_ar_ready;
   logic [ADDR_W-1:0] if_addr;
   logic [LEN_W-1:0]  if_len;
   logic [1:0]        if_size;
   logic              if_r_valid, if_r_ready;
   logic [DATA_W-1:0] if_r_data;
   logic [1:0]        if_r_resp;
   logic              if_r_last;
   logic              mem_ar_valid, mem_ar_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [LEN_W-1:0]  mem_len;
   logic [1:0]        mem_size;
   logic              mem_r_valid, mem_r_ready;
   logic [DATA_W-1:0] mem_r_data;
   logic [1:0]        mem_r_resp;
   logic              mem_r_last;
   logic              axi_ar_valid, axi_ar_ready;
   logic [ADDR_W-1:0] axi_ar_addr;
   logic [LEN_W-1:0]  axi_ar_len;
   logic [2:0]        axi_ar_size;
   logic [3:0]        axi_ar_id;
   logic              axi_r_valid, axi_r_ready;
   logic [DATA_W-1:0] axi_r_data;
   logic [1:0]        axi_r_resp;
   logic              axi_r_last;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .reset(reset),
      .if_ar_valid(if_ar_valid), .if_ar_ready(if_ar_ready), .if_addr(if_addr),
      .if_len(if_len), .if_size(if_size), .if_r_valid(if_r_valid),
      .if_r_ready(if_r_ready), .if_r_data(if_r_data), .if_r_resp(if_r_resp),
      .if_r_last(if_r_last),
      .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_addr(mem_addr),
      .mem_len(mem_len), .mem_size(mem_size), .mem_r_valid(mem_r_valid),
      .mem_r_ready(mem_r_ready), .mem_r_data(mem_r_data), .mem_r_resp(mem_r_resp),
      .mem_r_last(mem_r_last),
      .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
      .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size), .axi_ar_id(axi_ar_id),
      .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
      .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: the transaction in flight, described by its phase and captured request.
   int                mPhase;
   bit                mOwnerMem;
   bit                mLastMem;
   logic [ADDR_W-1:0] mAddr;
   logic [LEN_W-1:0]  mLen;
   logic [1:0]        mSize;
   int                grantsIf, grantsMem, completed;

   // Handshakes observed in the current cycle, used by the stimulus side.
   bit                hsIfAr, hsMemAr, hsAxiAr, hsR;
   logic [LEN_W-1:0]  seenLen;
   int                arHsCount = 0;

   // Randomized traffic generator state.
   bit                ifPend, memPend, slaveSpurious;
   int                slaveBeats;

   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic resetModel();
      mPhase    = PH_FREE;
      mOwnerMem = 1'b0;
      mLastMem  = 1'b0;
      mAddr     = '0;
      mLen      = '0;
      mSize     = '0;
   endtask

   // -1: nobody asks, 0: IF wins, 1: MEM wins.
   function automatic int pickWinner();
      if (if_ar_valid && mem_ar_valid) begin
`ifdef YSYX_22041071_ARB_RR_EN
         return mLastMem ? 0 : 1;
`else
         return 1;
`endif
      end
      if (mem_ar_valid) return 1;
      if (if_ar_valid) return 0;
      return -1;
   endfunction

   task automatic checkOutput();
      int   w;
      logic eIfRdy, eMemRdy, eIfRv, eMemRv, eRReady;
      if (!reset) resetModel();
      w       = pickWinner();
      eIfRdy  = reset && mPhase == PH_FREE && w == 0;
      eMemRdy = reset && mPhase == PH_FREE && w == 1;
      eIfRv   = mPhase == PH_DATA && !mOwnerMem && axi_r_valid;
      eMemRv  = mPhase == PH_DATA && mOwnerMem && axi_r_valid;
      eRReady = mPhase == PH_DATA && (mOwnerMem ? mem_r_ready : if_r_ready);
      checkValue("if_ar_ready", 64'(if_ar_ready), 64'(eIfRdy));
      checkValue("mem_ar_ready", 64'(mem_ar_ready), 64'(eMemRdy));
      checkValue("axi_ar_valid", 64'(axi_ar_valid), 64'(mPhase == PH_ADDR));
      checkValue("axi_ar_addr", 64'(axi_ar_addr), 64'(mAddr));
      checkValue("axi_ar_len", 64'(axi_ar_len), 64'(mLen));
      checkValue("axi_ar_size", 64'(axi_ar_size), 64'(mSize));
      checkValue("axi_ar_id", 64'(axi_ar_id), mAddr == '0 && mPhase == PH_FREE && !mOwnerMem ? 64'(axi_ar_id & 4'h1) : 64'(mOwnerMem));
      checkValue("axi_r_ready", 64'(axi_r_ready), 64'(eRReady));
      checkValue("if_r_valid", 64'(if_r_valid), 64'(eIfRv));
      checkValue("mem_r_valid", 64'(mem_r_valid), 64'(eMemRv));
      if (eIfRv) begin
         checkValue("if_r_data", 64'(if_r_data), 64'(axi_r_data));
         checkValue("if_r_resp", 64'(if_r_resp), 64'(axi_r_resp));
         checkValue("if_r_last", 64'(if_r_last), 64'(axi_r_last));
      end
      if (eMemRv) begin
         checkValue("mem_r_data", 64'(mem_r_data), 64'(axi_r_data));
         checkValue("mem_r_resp", 64'(mem_r_resp), 64'(axi_r_resp));
         checkValue("mem_r_last", 64'(mem_r_last), 64'(axi_r_last));
      end
   endtask

   task automatic updateModel();
      int w;
      if (!reset) begin
         resetModel();
         return;
      end
      case (mPhase)
         PH_FREE: begin
            w = pickWinner();
            if (w >= 0) begin
               mPhase    = PH_ADDR;
               mOwnerMem = (w == 1);
               mLastMem  = (w == 1);
               mAddr     = (w == 1) ? mem_addr : if_addr;
               mLen      = (w == 1) ? mem_len : if_len;
               mSize     = (w == 1) ? mem_size : if_size;
               if (w == 1) grantsMem++;
               else grantsIf++;
            end
         end
         PH_ADDR: if (axi_ar_ready) mPhase = PH_DATA;
         default: begin
            if (axi_r_valid && axi_r_last && (mOwnerMem ? mem_r_ready : if_r_ready)) begin
               mPhase = PH_FREE;
               completed++;
            end
         end
      endcase
   endtask

   task automatic recordHandshakes();
      hsIfAr  = if_ar_valid && if_ar_ready;
      hsMemAr = mem_ar_valid && mem_ar_ready;
      hsAxiAr = axi_ar_valid && axi_ar_ready;
      hsR     = axi_r_valid && axi_r_ready;
      seenLen = axi_ar_len;
      if (hsAxiAr) arHsCount++;
   endtask

   task automatic sampleEdge();
      @(negedge clk);
      checkOutput();
      recordHandshakes();
   endtask

   task automatic advance();
      updateModel();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle();
      sampleEdge();
      advance();
   endtask

   task automatic idleInputs();
      if_ar_valid  = 1'b0; if_addr = '0; if_len = '0; if_size = '0; if_r_ready = 1'b0;
      mem_ar_valid = 1'b0; mem_addr = '0; mem_len = '0; mem_size = '0; mem_r_ready = 1'b0;
      axi_ar_ready = 1'b0; axi_r_valid = 1'b0; axi_r_data = '0; axi_r_resp = '0; axi_r_last = 1'b0;
   endtask

   task automatic singleBeat(input logic [DATA_W-1:0] data);
      axi_ar_ready = 1'b0;
      axi_r_valid  = 1'b1;
      axi_r_data   = data;
      axi_r_last   = 1'b1;
      if_r_ready   = 1'b1;
      mem_r_ready  = 1'b1;
      cycle();
      axi_r_valid  = 1'b0;
      axi_r_last   = 1'b0;
   endtask

   task automatic applyStimulus();
      if (hsIfAr) ifPend = 1'b0;
      if (hsMemAr) memPend = 1'b0;
      if (!ifPend && $urandom_range(7) == 0) begin
         ifPend  = 1'b1;
         if_addr = {$urandom, $urandom};
         if_len  = LEN_W'($urandom_range(3));
         if_size = 2'($urandom_range(3));
      end
      if (!memPend && $urandom_range(11) == 0) begin
         memPend  = 1'b1;
         mem_addr = {$urandom, $urandom};
         mem_len  = LEN_W'($urandom_range(3));
         mem_size = 2'($urandom_range(3));
      end
      if_ar_valid  = ifPend;
      mem_ar_valid = memPend;
      if_r_ready   = ($urandom_range(3) != 0);
      mem_r_ready  = ($urandom_range(3) != 0);
      axi_ar_ready = ($urandom_range(2) == 0);
      if (hsAxiAr) slaveBeats = int'(seenLen) + 1;
      if (slaveSpurious) begin
         axi_r_valid   = 1'b0;
         slaveSpurious = 1'b0;
      end else if (hsR) begin
         slaveBeats--;
         axi_r_valid = 1'b0;
      end
      if (!axi_r_valid) begin
         if (slaveBeats > 0) begin
            if ($urandom_range(3) != 0) begin
               axi_r_valid = 1'b1;
               axi_r_data  = {$urandom, $urandom};
               axi_r_resp  = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'b00;
               axi_r_last  = (slaveBeats == 1);
            end
         end else if ($urandom_range(7) == 0) begin
            axi_r_valid   = 1'b1;
            slaveSpurious = 1'b1;
            axi_r_data    = {$urandom, $urandom};
            axi_r_resp    = 2'($urandom_range(3));
            axi_r_last    = 1'($urandom_range(1));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int hsBefore;
      int beat;
      int guard;
      int doneBefore;

      idleInputs();
      reset = 1'b0;
      resetModel();
      grantsIf = 0; grantsMem = 0; completed = 0;

      // Reset holds everything quiet even with a pending request.
      if_ar_valid = 1'b1; if_addr = 64'h8000_0000; if_len = 8'd0; if_size = 2'd3;
      @(posedge clk); #1;
      sampleEdge();
      checkValue("reset_if_ar_ready", 64'(if_ar_ready), 64'd0);
      checkValue("reset_axi_ar_valid", 64'(axi_ar_valid), 64'd0);
      checkValue("reset_axi_ar_addr", 64'(axi_ar_addr), 64'd0);
      checkValue("reset_axi_ar_id", 64'(axi_ar_id), 64'd0);
      advance();
      reset = 1'b1;

      // Single IF read.
      sampleEdge();
      checkValue("t1_if_ar_ready", 64'(if_ar_ready), 64'd1);
      checkValue("t1_mem_ar_ready", 64'(mem_ar_ready), 64'd0);
      checkValue("t1_ar_valid_lat", 64'(axi_ar_valid), 64'd0);
      advance();
      if_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      sampleEdge();
      checkValue("t1_ar_valid", 64'(axi_ar_valid), 64'd1);
      checkValue("t1_ar_id", 64'(axi_ar_id), 64'd0);
      checkValue("t1_ar_addr", 64'(axi_ar_addr), 64'h8000_0000);
      checkValue("t1_ar_size", 64'(axi_ar_size), 64'd3);
      advance();
      axi_ar_ready = 1'b0; axi_r_valid = 1'b1; axi_r_data = 64'h1234; axi_r_last = 1'b1; if_r_ready = 1'b1;
      sampleEdge();
      checkValue("t1_if_r_valid", 64'(if_r_valid), 64'd1);
      checkValue("t1_if_r_data", 64'(if_r_data), 64'h1234);
      checkValue("t1_mem_r_valid", 64'(mem_r_valid), 64'd0);
      advance();
      idleInputs();

      // Contention: MEM first, IF after MEM's last beat; error response passes through.
      if_ar_valid = 1'b1; if_addr = 64'h8000_2000; if_len = 8'd0; if_size = 2'd2;
      mem_ar_valid = 1'b1; mem_addr = 64'h8000_1000; mem_len = 8'd0; mem_size = 2'd3;
      sampleEdge();
      checkValue("t2_mem_ar_ready", 64'(mem_ar_ready), 64'd1);
      checkValue("t2_if_ar_ready", 64'(if_ar_ready), 64'd0);
      advance();
      mem_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      sampleEdge();
      checkValue("t2_ar_id", 64'(axi_ar_id), 64'd1);
      checkValue("t2_ar_addr", 64'(axi_ar_addr), 64'h8000_1000);
      advance();
      axi_ar_ready = 1'b0; axi_r_valid = 1'b1; axi_r_data = 64'hA5; axi_r_resp = 2'd2;
      axi_r_last = 1'b1; mem_r_ready = 1'b1;
      sampleEdge();
      checkValue("t2_mem_r_resp", 64'(mem_r_resp), 64'd2);
      checkValue("t2_if_wait", 64'(if_ar_ready), 64'd0);
      advance();
      axi_r_valid = 1'b0; axi_r_resp = 2'd0; mem_r_ready = 1'b0;
      sampleEdge();
      checkValue("t2_if_granted", 64'(if_ar_ready), 64'd1);
      advance();
      if_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      sampleEdge();
      checkValue("t2_if_ar_addr", 64'(axi_ar_addr), 64'h8000_2000);
      advance();
      singleBeat(64'h55);
      idleInputs();

      // AR stalled for five cycles: fields hold, exactly one handshake.
      if_ar_valid = 1'b1; if_addr = 64'h8000_0040; if_len = 8'd2; if_size = 2'd3;
      cycle();
      if_ar_valid = 1'b0;
      hsBefore = arHsCount;
      for (int i = 0; i < 5; i++) begin
         sampleEdge();
         checkValue("t3_hold_valid", 64'(axi_ar_valid), 64'd1);
         checkValue("t3_hold_addr", 64'(axi_ar_addr), 64'h8000_0040);
         checkValue("t3_hold_len", 64'(axi_ar_len), 64'd2);
         checkValue("t3_hold_id", 64'(axi_ar_id), 64'd0);
         advance();
      end
      axi_ar_ready = 1'b1;
      cycle();
      axi_ar_ready = 1'b0;
      if_r_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         axi_r_valid = 1'b1; axi_r_data = 64'(b + 7); axi_r_last = (b == 2);
         sampleEdge();
         if (b == 0) checkValue("t3_ar_valid_drop", 64'(axi_ar_valid), 64'd0);
         advance();
      end
      checkValue("t3_one_handshake", 64'(arHsCount - hsBefore), 64'd1);
      idleInputs();

      // MEM burst of four with toggling ready; IF request raised mid-burst must wait.
      mem_ar_valid = 1'b1; mem_addr = 64'h8000_3000; mem_len = 8'd3; mem_size = 2'd3;
      cycle();
      mem_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      cycle();
      axi_ar_ready = 1'b0;
      if_ar_valid = 1'b1; if_addr = 64'h8000_4000; if_len = 8'd0; if_size = 2'd3;
      beat = 0;
      guard = 0;
      while (beat < 4 && guard < 20) begin
         mem_r_ready = (guard % 2 == 0);
         axi_r_valid = 1'b1; axi_r_data = 64'(256 + beat); axi_r_last = (beat == 3);
         sampleEdge();
         checkValue("t4_r_ready_mirror", 64'(axi_r_ready), 64'(guard % 2 == 0));
         checkValue("t4_beat_order", 64'(mem_r_data), 64'(256 + beat));
         checkValue("t4_if_blocked", 64'(if_ar_ready), 64'd0);
         if (mem_r_ready) beat++;
         advance();
         guard++;
      end
      checkValue("t4_beats_delivered", 64'(beat), 64'd4);
      axi_r_valid = 1'b0; axi_r_last = 1'b0; mem_r_ready = 1'b0;
      sampleEdge();
      checkValue("t4_if_granted", 64'(if_ar_ready), 64'd1);
      advance();
      if_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      cycle();
      singleBeat(64'h77);
      idleInputs();

      // Reset mid-burst clears immediately, then a fresh IF request is served.
      mem_ar_valid = 1'b1; mem_addr = 64'h8000_5000; mem_len = 8'd3; mem_size = 2'd3;
      cycle();
      mem_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      cycle();
      axi_ar_ready = 1'b0; mem_r_ready = 1'b1;
      for (int b = 0; b < 2; b++) begin
         axi_r_valid = 1'b1; axi_r_data = 64'(b + 40); axi_r_last = 1'b0;
         cycle();
      end
      reset = 1'b0;
      sampleEdge();
      checkValue("t5_ar_valid", 64'(axi_ar_valid), 64'd0);
      checkValue("t5_r_ready", 64'(axi_r_ready), 64'd0);
      checkValue("t5_mem_r_valid", 64'(mem_r_valid), 64'd0);
      checkValue("t5_if_r_valid", 64'(if_r_valid), 64'd0);
      advance();
      idleInputs();
      cycle();
      reset = 1'b1;
      if_ar_valid = 1'b1; if_addr = 64'h8000_6000; if_len = 8'd0; if_size = 2'd3;
      sampleEdge();
      checkValue("t5_if_after_reset", 64'(if_ar_ready), 64'd1);
      advance();
      if_ar_valid = 1'b0; axi_ar_ready = 1'b1;
      cycle();
      singleBeat(64'h99);
      idleInputs();
      cycle();

      // Randomized traffic against the model.
      ifPend = 1'b0; memPend = 1'b0; slaveSpurious = 1'b0; slaveBeats = 0;
      hsIfAr = 1'b0; hsMemAr = 1'b0; hsAxiAr = 1'b0; hsR = 1'b0;
      grantsIf = 0; grantsMem = 0;
      doneBefore = completed;
      for (int i = 0; i < 4000; i++) begin
         applyStimulus();
         cycle();
      end
      checkValue("rand_progress", 64'(completed - doneBefore >= 40), 64'd1);
      checkValue("rand_if_served", 64'(grantsIf >= 5), 64'd1);
      checkValue("rand_mem_served", 64'(grantsMem >= 5), 64'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
